mips_multicycle_ctrl: RTL and testbench

//  Main control FSM of the multicycle MIPS datapath; directly upstream of the ALU function decoder.

---
 rtl/mips_pkg.sv | 68 ++++++
 rtl/mips_ctrl_outdec.sv | 76 +++++++
 rtl/mips_multicycle_ctrl.sv | 101 ++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states, ALU/PC selects, control word.
// BNE_SUPPORT_EN adds the bne opcode and its execute state.
package mips_pkg;

  localparam int unsigned OP_W       = 6;
  localparam int unsigned ST_ENC_W   = 4;
  localparam int unsigned ALUOP_W    = 2;
  localparam int unsigned ALUSRCB_W  = 2;
  localparam int unsigned PCSRC_W    = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
`ifdef BNE_SUPPORT_EN
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [ALUSRCB_W-1:0] ALUSRCB_RT    = 2'b00;
  localparam logic [ALUSRCB_W-1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [ALUSRCB_W-1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [ALUSRCB_W-1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [PCSRC_W-1:0] PCSRC_ALURES = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [ST_ENC_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
`ifdef BNE_SUPPORT_EN
    , BNEEX = 4'd12
`endif
  } state_e;

  typedef struct packed {
    logic                 iord;
    logic                 irwrite;
    logic                 memwrite;
    logic                 regdst;
    logic                 memtoreg;
    logic                 regwrite;
    logic                 alusrca;
    logic [ALUSRCB_W-1:0] alusrcb;
    logic [ALUOP_W-1:0]   aluop;
    logic [PCSRC_W-1:0]   pcsrc;
    logic                 pcwrite;
    logic                 branch;
    logic                 branchne;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Moore decode of the control FSM state into the datapath control word.
// BNE_SUPPORT_EN adds the BNEEX decode.
module mips_ctrl_outdec
  import mips_pkg::*;
(
  input  state_e state,
  input  logic   memready,
  output ctrl_t  ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    case (state)
      FETCH: begin
        ctrl_c.alusrcb = ALUSRCB_FOUR;
        ctrl_c.aluop   = ALUOP_ADD;
        ctrl_c.pcsrc   = PCSRC_ALURES;
        // IR load and PC+4 commit only when the instruction word arrives
        ctrl_c.irwrite = memready;
        ctrl_c.pcwrite = memready;
      end
      DECODE: begin
        ctrl_c.alusrcb = ALUSRCB_IMMSH;
        ctrl_c.aluop   = ALUOP_ADD;
      end
      MEMADR: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.alusrcb = ALUSRCB_IMM;
        ctrl_c.aluop   = ALUOP_ADD;
      end
      MEMRD: ctrl_c.iord = 1'b1;
      MEMWB: begin
        ctrl_c.memtoreg = 1'b1;
        ctrl_c.regwrite = 1'b1;
      end
      MEMWR: begin
        ctrl_c.iord     = 1'b1;
        ctrl_c.memwrite = 1'b1;
      end
      RTYPEEX: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.alusrcb = ALUSRCB_RT;
        ctrl_c.aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        ctrl_c.regdst   = 1'b1;
        ctrl_c.regwrite = 1'b1;
      end
      BEQEX: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.aluop   = ALUOP_SUB;
        ctrl_c.pcsrc   = PCSRC_ALUOUT;
        ctrl_c.branch  = 1'b1;
      end
      ADDIEX: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.alusrcb = ALUSRCB_IMM;
      end
      ADDIWB: ctrl_c.regwrite = 1'b1;
      JEX: begin
        ctrl_c.pcsrc   = PCSRC_JUMP;
        ctrl_c.pcwrite = 1'b1;
      end
`ifdef BNE_SUPPORT_EN
      BNEEX: begin
        ctrl_c.alusrca  = 1'b1;
        ctrl_c.aluop    = ALUOP_SUB;
        ctrl_c.pcsrc    = PCSRC_ALUOUT;
        ctrl_c.branchne = 1'b1;
      end
`endif
      default: ctrl_c = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath; sequences fetch/decode/execute/mem/writeback.
// Optional macro BNE_SUPPORT_EN enables the bne instruction.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [OP_W-1:0]    op,
  input  logic               memready,
  input  logic               zero,
  output logic               iord,
  output logic               irwrite,
  output logic               memwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsrc,
  output logic               pcwrite,
  output logic               branch,
  output logic               branchne,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  ctrl_t  ctrl_c;
  logic   unused_zero;

  // zero is consumed by the datapath PC logic, not by this FSM
  assign unused_zero = zero;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = FETCH;
    illegal_d = illegal_q;
    case (state_q)
      FETCH:   state_d = memready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
`ifdef BNE_SUPPORT_EN
          OP_BNE:       state_d = BNEEX;
`endif
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = memready ? MEMWB : MEMRD;
      MEMWR:   state_d = memready ? FETCH : MEMWR;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state    (state_q),
    .memready (memready),
    .ctrl_c   (ctrl_c)
  );

  // Write enables are squashed while reset is held so no strobe escapes in the reset cycle
  assign iord     = ctrl_c.iord;
  assign irwrite  = ctrl_c.irwrite  & resetn;
  assign memwrite = ctrl_c.memwrite & resetn;
  assign regdst   = ctrl_c.regdst;
  assign memtoreg = ctrl_c.memtoreg;
  assign regwrite = ctrl_c.regwrite & resetn;
  assign alusrca  = ctrl_c.alusrca;
  assign alusrcb  = ctrl_c.alusrcb;
  assign aluop    = ctrl_c.aluop;
  assign pcsrc    = ctrl_c.pcsrc;
  assign pcwrite  = ctrl_c.pcwrite  & resetn;
  assign branch   = ctrl_c.branch   & resetn;
  assign branchne = ctrl_c.branchne & resetn;
  assign illegal  = illegal_q;
  assign state    = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-cycle expected control words queued by the driver,
// popped and compared by a negedge monitor.
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  localparam int unsigned STATE_W = 4;

  logic               clk = 1'b0;
  logic               resetn, memready, zero;
  logic [5:0]         op;
  logic               iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0]         alusrcb, aluop, pcsrc;
  logic               pcwrite, branch, branchne, illegal;
  logic [STATE_W-1:0] state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.STATE_W(STATE_W)) dut (
    .clk(clk), .resetn(resetn), .op(op), .memready(memready), .zero(zero),
    .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsrc(pcsrc), .pcwrite(pcwrite), .branch(branch),
    .branchne(branchne), .illegal(illegal), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       pcwrite, branch, branchne, illegal;
  } snap_t;

  snap_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_cyc = 0;
  logic  ill_m = 1'b0;

  // Expected outputs straight from the per-state control table
  function automatic snap_t model(input state_e st, input logic ill, input logic mr, input logic rn);
    snap_t s;
    s = '0;
    s.st = 4'(st);
    s.illegal = ill;
    case (st)
      FETCH:   begin s.alusrcb = 2'b01; s.irwrite = mr; s.pcwrite = mr; end
      DECODE:  s.alusrcb = 2'b11;
      MEMADR:  begin s.alusrca = 1'b1; s.alusrcb = 2'b10; end
      MEMRD:   s.iord = 1'b1;
      MEMWB:   begin s.memtoreg = 1'b1; s.regwrite = 1'b1; end
      MEMWR:   begin s.iord = 1'b1; s.memwrite = 1'b1; end
      RTYPEEX: begin s.alusrca = 1'b1; s.aluop = 2'b10; end
      RTYPEWB: begin s.regdst = 1'b1; s.regwrite = 1'b1; end
      BEQEX:   begin s.alusrca = 1'b1; s.aluop = 2'b01; s.pcsrc = 2'b01; s.branch = 1'b1; end
      ADDIEX:  begin s.alusrca = 1'b1; s.alusrcb = 2'b10; end
      ADDIWB:  s.regwrite = 1'b1;
      JEX:     begin s.pcsrc = 2'b10; s.pcwrite = 1'b1; end
`ifdef BNE_SUPPORT_EN
      BNEEX:   begin s.alusrca = 1'b1; s.aluop = 2'b01; s.pcsrc = 2'b01; s.branchne = 1'b1; end
`endif
      default: s = '0;
    endcase
    if (!rn) begin
      s.irwrite = 1'b0; s.memwrite = 1'b0; s.regwrite = 1'b0;
      s.pcwrite = 1'b0; s.branch = 1'b0; s.branchne = 1'b0;
    end
    return s;
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // One clock: drive inputs for the cycle and queue what the outputs must be during it
  task automatic step(input state_e st, input logic [5:0] o, input logic mr, input logic rn);
    @(posedge clk);
    #1;
    resetn   = rn;
    op       = o;
    memready = mr;
    zero     = rbit();
    if (!rn) ill_m = 1'b0;
    exp_q.push_back(model(rn ? st : FETCH, ill_m, mr, rn));
  endtask

  // Instruction-level reference: the state walk an opcode takes, with fw/mw memory wait cycles
  task automatic run_instr(input logic [5:0] opc, input int fw, input int mw);
    repeat (fw) step(FETCH, rop(), 1'b0, 1'b1);
    step(FETCH, rop(), 1'b1, 1'b1);
    step(DECODE, opc, rbit(), 1'b1);
    case (opc)
      6'b100011: begin
        step(MEMADR, opc, rbit(), 1'b1);
        repeat (mw) step(MEMRD, rop(), 1'b0, 1'b1);
        step(MEMRD, rop(), 1'b1, 1'b1);
        step(MEMWB, rop(), rbit(), 1'b1);
      end
      6'b101011: begin
        step(MEMADR, opc, rbit(), 1'b1);
        repeat (mw) step(MEMWR, rop(), 1'b0, 1'b1);
        step(MEMWR, rop(), 1'b1, 1'b1);
      end
      6'b000000: begin
        step(RTYPEEX, rop(), rbit(), 1'b1);
        step(RTYPEWB, rop(), rbit(), 1'b1);
      end
      6'b000100: step(BEQEX, rop(), rbit(), 1'b1);
      6'b001000: begin
        step(ADDIEX, rop(), rbit(), 1'b1);
        step(ADDIWB, rop(), rbit(), 1'b1);
      end
      6'b000010: step(JEX, rop(), rbit(), 1'b1);
`ifdef BNE_SUPPORT_EN
      6'b000101: step(BNEEX, rop(), rbit(), 1'b1);
`endif
      default: ill_m = 1'b1;
    endcase
  endtask

  always @(negedge clk) begin
    snap_t a, e;
    n_cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{st: state[3:0], iord: iord, irwrite: irwrite, memwrite: memwrite, regdst: regdst,
            memtoreg: memtoreg, regwrite: regwrite, alusrca: alusrca, alusrcb: alusrcb,
            aluop: aluop, pcsrc: pcsrc, pcwrite: pcwrite, branch: branch,
            branchne: branchne, illegal: illegal};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL ctrl_word cyc=%0d state act=%0d req=%0d word act=%h req=%h",
                 n_cyc, a.st, e.st, a, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [5:0] opc;
    resetn = 1'b0; memready = 1'b1; op = 6'd0; zero = 1'b0;

    // Reset state with memready high: no IR/PC strobes
    step(FETCH, 6'b100011, 1'b1, 1'b0);
    step(FETCH, 6'b000000, 1'b1, 1'b0);

    run_instr(6'b100011, 0, 0);
    run_instr(6'b101011, 0, 3);
    run_instr(6'b000000, 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b001000, 1, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b001000, 0, 0);
    step(FETCH, rop(), 1'b1, 1'b0);
    run_instr(6'b000101, 0, 0);
    run_instr(6'b100011, 2, 2);

    // Reset while a store is stalled in MEMWR
    step(FETCH, rop(), 1'b1, 1'b1);
    step(DECODE, 6'b101011, rbit(), 1'b1);
    step(MEMADR, 6'b101011, rbit(), 1'b1);
    step(MEMWR, rop(), 1'b0, 1'b1);
    step(MEMWR, rop(), 1'b0, 1'b0);
    run_instr(6'b000000, 0, 0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 8: opc = 6'b100011;
        1:    opc = 6'b101011;
        2, 9: opc = 6'b000000;
        3:    opc = 6'b000100;
        4:    opc = 6'b001000;
        5:    opc = 6'b000010;
        6:    opc = 6'b000101;
        default: opc = rop();
      endcase
      if ($urandom_range(0, 29) == 0) step(FETCH, rop(), rbit(), 1'b0);
      run_instr(opc, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending act=%0d req=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
